multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter FLAG_WIDTH, default 32, width of NFlag.
REQ-002 SHALL have parameter FLAG_BIT_ZERO, default 0, NFlag bit index of the ALU zero flag.
REQ-003 SHALL have parameter FLAG_BIT_OVERFLOW, default 1, NFlag bit index of the ALU overflow flag.
REQ-004 SHALL have parameter EXT_ISA, default 1; 1 enables addi/addiu/slt/jal/jr, 0 treats them as illegal.
REQ-005 SHALL have parameter MEM_TIMEOUT, default 16; memory-wait cycle limit, 0 disables the limit.
REQ-006 SHALL have parameter CNT_WIDTH, default 32, width of the retired-instruction counter.
REQ-007 SHALL have port clk  input  1  clock; all state updates occur on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have ports opcode and funct  input  6 each  instruction fields taken from the datapath IR.
REQ-010 SHALL have port NFlag  input  FLAG_WIDTH  ALU flags.
REQ-011 SHALL have port mem_ready  input  1  memory access-complete strobe.
REQ-012 SHALL have outputs PCWr, IRWr, RegWr, MemRd, MemWr and ALUSrc  output  1 each  strobe or select.
REQ-013 SHALL have outputs RegDst, Mem2Reg, NPCSel, EXTOp and FlagOp  output  2 each; ALUOp  output  3; all use the shared macro encodings.
REQ-014 SHALL have outputs state  output  3  current FSM state; illegal  output  1; bus_err  output  1; retired  output  CNT_WIDTH.

Function
REQ-015 SHALL use the state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-016 SHALL decode outputs combinationally from state, opcode, funct and NFlag; any strobe or mux field not listed for a state SHALL be 0.
REQ-017 FETCH SHALL assert MemRd; when mem_ready=1 it SHALL also assert IRWr, PCWr and NPCSel=NPC_SEL_PC_ADD_4, then go to DECODE; otherwise it stays in FETCH.
REQ-018 DECODE with an unsupported opcode/funct SHALL go to HALT and set illegal.
REQ-019 DECODE j SHALL assert PCWr with NPCSel=J_JMP and go to FETCH; jr SHALL assert PCWr with NPCSel=REG_JMP and go to FETCH.
REQ-020 DECODE jal SHALL assert PCWr (NPCSel=J_JMP) and RegWr (RegDst=RET, Mem2Reg=RET) and go to FETCH.
REQ-021 All other legal instructions in DECODE SHALL go to EXEC.
REQ-022 EXEC SHALL drive ALUOp/ALUSrc/EXTOp as follows: addu ADD,B; subu SUB,B; slt LESS,B; ori OR,EXT,ZERO; lui OR,EXT,LUI; lw/sw/addi/addiu ADD,EXT,SIGN; beq SUB,B.
REQ-023 EXEC beq SHALL assert PCWr with NPCSel=BEQ_JMP only if NFlag[FLAG_BIT_ZERO]=1, then go to FETCH.
REQ-024 EXEC lw/sw SHALL go to MEM; every other instruction SHALL go to WB.
REQ-025 MEM lw SHALL assert MemRd, hold ALU controls, and go to WB on mem_ready.
REQ-026 MEM sw SHALL assert MemWr, hold ALU controls, and go to FETCH on mem_ready.
REQ-027 WB SHALL assert RegWr with RegDst=RD for R-type and RT otherwise, and Mem2Reg=RAM for lw and ALU otherwise, then go to FETCH.
REQ-028 WB addi with NFlag[FLAG_BIT_OVERFLOW]=1 SHALL deassert RegWr and drive FlagOp=SET.
REQ-029 SHALL keep a wait counter that clears on entering FETCH or MEM and increments each cycle without mem_ready; if MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT, it SHALL go to HALT and set bus_err.
REQ-030 HALT SHALL hold all strobes at 0 and remain until reset; illegal and bus_err are sticky.
REQ-031 retired SHALL increment by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB and wrap modulo 2^CNT_WIDTH.
REQ-032 With mem_ready always 1, cycles per instruction SHALL be: j/jr/jal 2, beq 3, R-type/imm 4, sw 4, lw 5.

Reset
REQ-033 rst_n=0 SHALL immediately force state=FETCH, clear the wait counter, retired, illegal and bus_err, and force all strobes to 0, regardless of the current state, including mid-MEM.
REQ-034 The first MemRd SHALL appear in the cycle after rst_n deasserts.

Verification
REQ-035 lw, mem_ready=1 throughout -> states 0,1,2,3,4; RegWr=1 and Mem2Reg=RAM only in cycle 5; retired=1.
REQ-036 beq with NFlag[0]=1, then beq with NFlag[0]=0 -> PCWr with BEQ_JMP in EXEC only for the first; each takes 3 cycles.
REQ-037 addi with NFlag[1]=1 in WB -> RegWr=0 and FlagOp=SET; retired still increments.
REQ-038 EXT_ISA=0 and slt fetched -> HALT in the cycle after DECODE, illegal=1, and no further PCWr.
REQ-039 MEM_TIMEOUT=4, sw with mem_ready held 0 -> MemWr high for 4 cycles, then HALT with bus_err=1.
REQ-040 rst_n pulsed low during MEM of lw -> state=0 and all strobes 0 asynchronously; no RegWr follows.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Memory handshake between the multicycle controller and instruction/data memory.
//   mem_ready : memory -> controller, access-complete strobe
//   MemRd     : controller -> memory, read request (fetch or load)
//   MemWr     : controller -> memory, write request (store)
interface multicycle_controller_if;
  logic mem_ready;
  logic MemRd;
  logic MemWr;

  modport master (input mem_ready, output MemRd, output MemWr);
  modport slave  (output mem_ready, input MemRd, input MemWr);
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, funct     : instruction fields from the datapath IR
//   NFlag             : ALU flags (zero / overflow bit positions are parameters)
//   bus               : memory handshake (mem_ready in, MemRd/MemWr out)
//   PCWr..ALUOp       : datapath strobes and mux selects, encodings below
//   state             : current FSM state
//   illegal, bus_err  : sticky fault flags, cleared only by reset
//   retired           : retired-instruction counter (wraps)
package multicycle_controller_pkg;
  localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'd0;
  localparam logic [1:0] NPC_SEL_J_JMP    = 2'd1;
  localparam logic [1:0] NPC_SEL_REG_JMP  = 2'd2;
  localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'd3;
  localparam logic [1:0] REG_DST_RT       = 2'd0;
  localparam logic [1:0] REG_DST_RD       = 2'd1;
  localparam logic [1:0] REG_DST_RET      = 2'd2;
  localparam logic [1:0] MEM2REG_ALU      = 2'd0;
  localparam logic [1:0] MEM2REG_RAM      = 2'd1;
  localparam logic [1:0] MEM2REG_RET      = 2'd2;
  localparam logic [1:0] EXT_OP_ZERO      = 2'd0;
  localparam logic [1:0] EXT_OP_SIGN      = 2'd1;
  localparam logic [1:0] EXT_OP_LUI       = 2'd2;
  localparam logic [1:0] FLAG_OP_NONE     = 2'd0;
  localparam logic [1:0] FLAG_OP_SET      = 2'd1;
  localparam logic [2:0] ALU_OP_ADD       = 3'd0;
  localparam logic [2:0] ALU_OP_SUB       = 3'd1;
  localparam logic [2:0] ALU_OP_OR        = 3'd2;
  localparam logic [2:0] ALU_OP_LESS      = 3'd3;
  localparam logic       ALU_SRC_B        = 1'b0;
  localparam logic       ALU_SRC_EXT      = 1'b1;
endpackage

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned FLAG_WIDTH        = 32,
  parameter int unsigned FLAG_BIT_ZERO     = 0,
  parameter int unsigned FLAG_BIT_OVERFLOW = 1,
  parameter int          EXT_ISA           = 1,
  parameter int unsigned MEM_TIMEOUT       = 16,
  parameter int unsigned CNT_WIDTH         = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic [FLAG_WIDTH-1:0]  NFlag,
  multicycle_controller_if.master bus,
  output logic                   PCWr,
  output logic                   IRWr,
  output logic                   RegWr,
  output logic                   ALUSrc,
  output logic [1:0]             RegDst,
  output logic [1:0]             Mem2Reg,
  output logic [1:0]             NPCSel,
  output logic [1:0]             EXTOp,
  output logic [1:0]             FlagOp,
  output logic [2:0]             ALUOp,
  output logic [2:0]             state,
  output logic                   illegal,
  output logic                   bus_err,
  output logic [CNT_WIDTH-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    I_ILL, I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI,
    I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ADDI, I_ADDIU
  } instr_e;

  localparam logic        EXT       = (EXT_ISA != 0);
  localparam logic [31:0] WAIT_LAST = (MEM_TIMEOUT == 0) ? '0 : 32'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  instr_e      ins;
  logic [31:0] wait_q;
  logic        tmo_hit, ill_set, berr_set, memrd, memwr;
  logic        alu_src_i;
  logic [1:0]  ext_op_i;
  logic [2:0]  alu_op_i;
  logic        flags_unused;

  assign flags_unused = ^NFlag;
  assign state        = state_q;
  assign bus.MemRd    = memrd;
  assign bus.MemWr    = memwr;
  // Reaching the limit on this edge: the cycle with wait_q == MEM_TIMEOUT-1 is the last one.
  assign tmo_hit = (MEM_TIMEOUT != 0) && !bus.mem_ready && (wait_q == WAIT_LAST);

  always_comb begin
    ins = I_ILL;
    case (opcode)
      6'b000000:
        case (funct)
          6'b100001: ins = I_ADDU;
          6'b100011: ins = I_SUBU;
          6'b101010: ins = EXT ? I_SLT : I_ILL;
          6'b001000: ins = EXT ? I_JR  : I_ILL;
          default:   ins = I_ILL;
        endcase
      6'b001101: ins = I_ORI;
      6'b001111: ins = I_LUI;
      6'b100011: ins = I_LW;
      6'b101011: ins = I_SW;
      6'b000100: ins = I_BEQ;
      6'b000010: ins = I_J;
      6'b000011: ins = EXT ? I_JAL   : I_ILL;
      6'b001000: ins = EXT ? I_ADDI  : I_ILL;
      6'b001001: ins = EXT ? I_ADDIU : I_ILL;
      default:   ins = I_ILL;
    endcase
  end

  // ALU controls per instruction, shared by EXEC and MEM (address held during access).
  always_comb begin
    alu_op_i  = ALU_OP_ADD;
    alu_src_i = ALU_SRC_B;
    ext_op_i  = EXT_OP_ZERO;
    case (ins)
      I_SUBU, I_BEQ: alu_op_i = ALU_OP_SUB;
      I_SLT:         alu_op_i = ALU_OP_LESS;
      I_ORI:   begin alu_op_i = ALU_OP_OR;  alu_src_i = ALU_SRC_EXT; ext_op_i = EXT_OP_ZERO; end
      I_LUI:   begin alu_op_i = ALU_OP_OR;  alu_src_i = ALU_SRC_EXT; ext_op_i = EXT_OP_LUI;  end
      I_LW, I_SW, I_ADDI, I_ADDIU:
               begin alu_op_i = ALU_OP_ADD; alu_src_i = ALU_SRC_EXT; ext_op_i = EXT_OP_SIGN; end
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so they drop immediately on reset, not at the next edge.
  always_comb begin
    state_d  = state_q;
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    ALUSrc   = ALU_SRC_B;
    RegDst   = REG_DST_RT;
    Mem2Reg  = MEM2REG_ALU;
    NPCSel   = NPC_SEL_PC_ADD_4;
    EXTOp    = EXT_OP_ZERO;
    FlagOp   = FLAG_OP_NONE;
    ALUOp    = ALU_OP_ADD;
    memrd    = 1'b0;
    memwr    = 1'b0;
    ill_set  = 1'b0;
    berr_set = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          memrd = 1'b1;
          if (bus.mem_ready) begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            NPCSel  = NPC_SEL_PC_ADD_4;
            state_d = S_DECODE;
          end else if (tmo_hit) begin
            berr_set = 1'b1;
            state_d  = S_HALT;
          end
        end
        S_DECODE:
          case (ins)
            I_ILL: begin ill_set = 1'b1; state_d = S_HALT; end
            I_J:   begin PCWr = 1'b1; NPCSel = NPC_SEL_J_JMP;   state_d = S_FETCH; end
            I_JR:  begin PCWr = 1'b1; NPCSel = NPC_SEL_REG_JMP; state_d = S_FETCH; end
            I_JAL: begin
              PCWr    = 1'b1;
              NPCSel  = NPC_SEL_J_JMP;
              RegWr   = 1'b1;
              RegDst  = REG_DST_RET;
              Mem2Reg = MEM2REG_RET;
              state_d = S_FETCH;
            end
            default: state_d = S_EXEC;
          endcase
        S_EXEC: begin
          ALUOp  = alu_op_i;
          ALUSrc = alu_src_i;
          EXTOp  = ext_op_i;
          if (ins == I_BEQ) begin
            if (NFlag[FLAG_BIT_ZERO]) begin
              PCWr   = 1'b1;
              NPCSel = NPC_SEL_BEQ_JMP;
            end
            state_d = S_FETCH;
          end else if (ins == I_LW || ins == I_SW) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          ALUOp  = alu_op_i;
          ALUSrc = alu_src_i;
          EXTOp  = ext_op_i;
          if (ins == I_SW) memwr = 1'b1;
          else             memrd = 1'b1;
          if (bus.mem_ready) begin
            state_d = (ins == I_SW) ? S_FETCH : S_WB;
          end else if (tmo_hit) begin
            berr_set = 1'b1;
            state_d  = S_HALT;
          end
        end
        S_WB: begin
          RegWr   = 1'b1;
          RegDst  = (opcode == 6'b000000) ? REG_DST_RD : REG_DST_RT;
          Mem2Reg = (ins == I_LW) ? MEM2REG_RAM : MEM2REG_ALU;
          if (ins == I_ADDI && NFlag[FLAG_BIT_OVERFLOW]) begin
            RegWr  = 1'b0;
            FlagOp = FLAG_OP_SET;
          end
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      retired <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (!bus.mem_ready && (state_q == S_FETCH || state_q == S_MEM))
        wait_q <= wait_q + 32'd1;
      if (state_d == S_FETCH && state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB})
        retired <= retired + CNT_WIDTH'(1);
      if (ill_set)  illegal <= 1'b1;
      if (berr_set) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  localparam int OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam int OP_J = 6'h02, OP_JAL = 6'h03, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam int OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_BAD = 6'h3f;
  localparam int F_ADDU = 6'h21, F_SUBU = 6'h23, F_SLT = 6'h2a, F_JR = 6'h08;
  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4, S_H = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic [31:0] nflag;

  logic pcwr0, irwr0, regwr0, alusrc0, ill0, berr0;
  logic [1:0] regdst0, m2r0, npc0, ext0, flg0;
  logic [2:0] aluop0, st0;
  logic [31:0] ret0;
  logic pcwr1, irwr1, regwr1, alusrc1, ill1, berr1;
  logic [1:0] regdst1, m2r1, npc1, ext1, flg1;
  logic [2:0] aluop1, st1;
  logic [31:0] ret1;

  multicycle_controller_if bus0 ();
  multicycle_controller_if bus1 ();

  multicycle_controller dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .NFlag(nflag), .bus(bus0),
    .PCWr(pcwr0), .IRWr(irwr0), .RegWr(regwr0), .ALUSrc(alusrc0), .RegDst(regdst0),
    .Mem2Reg(m2r0), .NPCSel(npc0), .EXTOp(ext0), .FlagOp(flg0), .ALUOp(aluop0),
    .state(st0), .illegal(ill0), .bus_err(berr0), .retired(ret0)
  );

  multicycle_controller #(.EXT_ISA(0), .MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .NFlag(nflag), .bus(bus1),
    .PCWr(pcwr1), .IRWr(irwr1), .RegWr(regwr1), .ALUSrc(alusrc1), .RegDst(regdst1),
    .Mem2Reg(m2r1), .NPCSel(npc1), .EXTOp(ext1), .FlagOp(flg1), .ALUOp(aluop1),
    .state(st1), .illegal(ill1), .bus_err(berr1), .retired(ret1)
  );

  logic [18:0] ctrl0, ctrl1;
  assign ctrl0 = {pcwr0, irwr0, regwr0, bus0.MemRd, bus0.MemWr, alusrc0,
                  regdst0, m2r0, npc0, ext0, flg0, aluop0};
  assign ctrl1 = {pcwr1, irwr1, regwr1, bus1.MemRd, bus1.MemWr, alusrc1,
                  regdst1, m2r1, npc1, ext1, flg1, aluop1};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [1:0]  nf;
    logic        mr;
    logic [2:0]  st;
    logic [18:0] ctrl;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ret;

  function automatic logic [18:0] ctl(input int pcwr, irwr, regwr, memrd, memwr, alusrc,
                                      input int regdst, m2r, npc, ext, flg, aluop);
    return {1'(pcwr), 1'(irwr), 1'(regwr), 1'(memrd), 1'(memwr), 1'(alusrc),
            2'(regdst), 2'(m2r), 2'(npc), 2'(ext), 2'(flg), 3'(aluop)};
  endfunction

  task automatic add(input int op, fn, nf, mr, st, input logic [18:0] c);
    vec_t v;
    v.op = 6'(op); v.fn = 6'(fn); v.nf = 2'(nf); v.mr = 1'(mr); v.st = 3'(st); v.ctrl = c;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic r);
    bus0.mem_ready = r;
    bus1.mem_ready = r;
  endtask

  // Called 1ns after a rising edge; leaves both DUTs in FETCH for the current cycle.
  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [18:0] cF, cEs, cWrt, cWrd;

  initial begin
    cF   = ctl(1, 1, 0, 1, 0, 0, 0, 0, NPC_SEL_PC_ADD_4, 0, 0, 0);
    cEs  = ctl(0, 0, 0, 0, 0, ALU_SRC_EXT, 0, 0, 0, EXT_OP_SIGN, 0, ALU_OP_ADD);
    cWrt = ctl(0, 0, 1, 0, 0, 0, REG_DST_RT, MEM2REG_ALU, 0, 0, 0, 0);
    cWrd = ctl(0, 0, 1, 0, 0, 0, REG_DST_RD, MEM2REG_ALU, 0, 0, 0, 0);

    add(OP_LW, 0, 0, 1, S_F, cF);   add(OP_LW, 0, 0, 1, S_D, '0);  add(OP_LW, 0, 0, 1, S_E, cEs);
    add(OP_LW, 0, 0, 1, S_M, ctl(0, 0, 0, 1, 0, ALU_SRC_EXT, 0, 0, 0, EXT_OP_SIGN, 0, ALU_OP_ADD));
    add(OP_LW, 0, 0, 1, S_W, ctl(0, 0, 1, 0, 0, 0, REG_DST_RT, MEM2REG_RAM, 0, 0, 0, 0));
    add(OP_SW, 0, 0, 0, S_F, ctl(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(OP_SW, 0, 0, 1, S_F, cF);   add(OP_SW, 0, 0, 1, S_D, '0);  add(OP_SW, 0, 0, 1, S_E, cEs);
    add(OP_SW, 0, 0, 1, S_M, ctl(0, 0, 0, 0, 1, ALU_SRC_EXT, 0, 0, 0, EXT_OP_SIGN, 0, ALU_OP_ADD));
    add(OP_R, F_ADDU, 0, 1, S_F, cF); add(OP_R, F_ADDU, 0, 1, S_D, '0);
    add(OP_R, F_ADDU, 0, 1, S_E, ctl(0, 0, 0, 0, 0, ALU_SRC_B, 0, 0, 0, 0, 0, ALU_OP_ADD));
    add(OP_R, F_ADDU, 0, 1, S_W, cWrd);
    add(OP_R, F_SUBU, 0, 1, S_F, cF); add(OP_R, F_SUBU, 0, 1, S_D, '0);
    add(OP_R, F_SUBU, 0, 1, S_E, ctl(0, 0, 0, 0, 0, ALU_SRC_B, 0, 0, 0, 0, 0, ALU_OP_SUB));
    add(OP_R, F_SUBU, 0, 1, S_W, cWrd);
    add(OP_R, F_SLT, 0, 1, S_F, cF);  add(OP_R, F_SLT, 0, 1, S_D, '0);
    add(OP_R, F_SLT, 0, 1, S_E, ctl(0, 0, 0, 0, 0, ALU_SRC_B, 0, 0, 0, 0, 0, ALU_OP_LESS));
    add(OP_R, F_SLT, 0, 1, S_W, cWrd);
    add(OP_ORI, 0, 0, 1, S_F, cF);  add(OP_ORI, 0, 0, 1, S_D, '0);
    add(OP_ORI, 0, 0, 1, S_E, ctl(0, 0, 0, 0, 0, ALU_SRC_EXT, 0, 0, 0, EXT_OP_ZERO, 0, ALU_OP_OR));
    add(OP_ORI, 0, 0, 1, S_W, cWrt);
    add(OP_LUI, 0, 0, 1, S_F, cF);  add(OP_LUI, 0, 0, 1, S_D, '0);
    add(OP_LUI, 0, 0, 1, S_E, ctl(0, 0, 0, 0, 0, ALU_SRC_EXT, 0, 0, 0, EXT_OP_LUI, 0, ALU_OP_OR));
    add(OP_LUI, 0, 0, 1, S_W, cWrt);
    add(OP_ADDIU, 0, 2, 1, S_F, cF); add(OP_ADDIU, 0, 2, 1, S_D, '0);
    add(OP_ADDIU, 0, 2, 1, S_E, cEs); add(OP_ADDIU, 0, 2, 1, S_W, cWrt);
    add(OP_ADDI, 0, 0, 1, S_F, cF);  add(OP_ADDI, 0, 0, 1, S_D, '0);
    add(OP_ADDI, 0, 0, 1, S_E, cEs); add(OP_ADDI, 0, 0, 1, S_W, cWrt);
    add(OP_ADDI, 0, 2, 1, S_F, cF);  add(OP_ADDI, 0, 2, 1, S_D, '0);
    add(OP_ADDI, 0, 2, 1, S_E, cEs);
    add(OP_ADDI, 0, 2, 1, S_W, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLAG_OP_SET, 0));
    add(OP_BEQ, 0, 1, 1, S_F, cF);  add(OP_BEQ, 0, 1, 1, S_D, '0);
    add(OP_BEQ, 0, 1, 1, S_E, ctl(1, 0, 0, 0, 0, 0, 0, 0, NPC_SEL_BEQ_JMP, 0, 0, ALU_OP_SUB));
    add(OP_BEQ, 0, 2, 1, S_F, cF);  add(OP_BEQ, 0, 2, 1, S_D, '0);
    add(OP_BEQ, 0, 2, 1, S_E, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALU_OP_SUB));
    add(OP_J, 0, 0, 1, S_F, cF);
    add(OP_J, 0, 0, 1, S_D, ctl(1, 0, 0, 0, 0, 0, 0, 0, NPC_SEL_J_JMP, 0, 0, 0));
    add(OP_JAL, 0, 0, 1, S_F, cF);
    add(OP_JAL, 0, 0, 1, S_D, ctl(1, 0, 1, 0, 0, 0, REG_DST_RET, MEM2REG_RET, NPC_SEL_J_JMP, 0, 0, 0));
    add(OP_R, F_JR, 0, 1, S_F, cF);
    add(OP_R, F_JR, 0, 1, S_D, ctl(1, 0, 0, 0, 0, 0, 0, 0, NPC_SEL_REG_JMP, 0, 0, 0));
    add(OP_BAD, 0, 0, 1, S_F, cF);  add(OP_BAD, 0, 0, 1, S_D, '0);
    add(OP_BAD, 0, 0, 1, S_H, '0);  add(OP_BAD, 0, 0, 0, S_H, '0);

    // Reset state: strobes must be low even though the state register reads FETCH.
    rst_n = 1'b0; opcode = '0; funct = '0; nflag = '0; set_ready(1'b1);
    step(); step();
    @(negedge clk);
    chk("reset state", st0, S_F);
    chk("reset ctrl", ctrl0, 0);
    chk("reset retired", ret0, 0);
    chk("reset flags", {ill0, berr0}, 0);
    step();
    rst_n = 1'b1;

    exp_ret = 0;
    for (int i = 0; i < tv.size(); i++) begin
      opcode = tv[i].op; funct = tv[i].fn; nflag = {30'b0, tv[i].nf}; set_ready(tv[i].mr);
      if (i > 0 && tv[i].st == 3'd0 && tv[i-1].st >= 3'd1 && tv[i-1].st <= 3'd4) exp_ret++;
      @(negedge clk);
      chk($sformatf("vec%0d state", i), st0, tv[i].st);
      chk($sformatf("vec%0d ctrl", i), ctrl0, tv[i].ctrl);
      chk($sformatf("vec%0d retired", i), ret0, exp_ret);
      step();
    end
    chk("table illegal", ill0, 1);
    chk("table bus_err", berr0, 0);
    chk("table retired total", ret0, 15);

    // Reset pulse in the middle of a stalled load.
    apply_reset();
    opcode = 6'(OP_LW); funct = '0; nflag = '0; set_ready(1'b1);
    @(negedge clk); chk("lwrst fetch", st0, S_F);
    step(); step(); set_ready(1'b0); step();
    @(negedge clk);
    chk("lwrst in mem", st0, S_M);
    chk("lwrst memrd", bus0.MemRd, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("lwrst async state", st0, S_F);
    chk("lwrst async ctrl", ctrl0, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lwrst after%0d state", k), st0, S_F);
      chk($sformatf("lwrst after%0d regwr", k), regwr0, 0);
      step();
    end
    chk("lwrst retired", ret0, 0);

    // slt is illegal without the extended ISA.
    apply_reset();
    opcode = 6'(OP_R); funct = 6'(F_SLT); set_ready(1'b1);
    @(negedge clk); chk("ill fetch", st1, S_F);
    step(); @(negedge clk);
    chk("ill decode", st1, S_D);
    chk("ill not yet", ill1, 0);
    step(); @(negedge clk);
    chk("ill halt", st1, S_H);
    chk("ill flag", ill1, 1);
    for (int k = 0; k < 3; k++) begin
      step(); @(negedge clk);
      chk($sformatf("ill hold%0d state", k), st1, S_H);
      chk($sformatf("ill hold%0d ctrl", k), ctrl1, 0);
    end

    // Store timeout with a 4-cycle limit; the default-limit instance keeps waiting.
    apply_reset();
    opcode = 6'(OP_SW); funct = '0; set_ready(1'b1);
    step(); step();
    @(negedge clk); chk("tmo exec", st1, S_E);
    set_ready(1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("tmo mem%0d state", k), st1, S_M);
      chk($sformatf("tmo mem%0d memwr", k), bus1.MemWr, 1);
      step();
    end
    @(negedge clk);
    chk("tmo halt", st1, S_H);
    chk("tmo bus_err", berr1, 1);
    chk("tmo memwr off", bus1.MemWr, 0);
    chk("tmo default still mem", st0, S_M);
    chk("tmo default no bus_err", berr0, 0);

    // Fetch timeout.
    apply_reset();
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("ftmo wait%0d", k), {st1, bus1.MemRd}, {3'(S_F), 1'b1});
      step();
    end
    @(negedge clk);
    chk("ftmo halt", st1, S_H);
    chk("ftmo bus_err", berr1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
